// File: rtl/p5_ring_counter.sv
// Rotating ring counter: a WIDTH-bit register that rotates toward the MSB each clock,
// with an asynchronous active-low clear and an asynchronous active-high load of SEED.
module p5_ring_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  output logic [WIDTH-1:0] q
);

  logic             loadSeed;
  logic [WIDTH-1:0] ring_q;
  logic [WIDTH-1:0] ring_d;

  // Gating preset with reset means reset releasing while preset is held also raises
  // loadSeed, so SEED appears at once instead of waiting for the next clock.
  assign loadSeed = reset & preset;

  always_comb begin
    ring_d = {ring_q[WIDTH-2:0], ring_q[WIDTH-1]};
  end

  always_ff @(posedge clk or negedge reset or posedge loadSeed) begin
    if (!reset) begin
      ring_q <= '0;
    end else if (loadSeed) begin
      ring_q <= SEED;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign q = ring_q;

endmodule

// File: tb/tb_p5_ring_counter.sv
// Randomized bench for p5_ring_counter: a default 4-bit instance and a 6-bit instance
// share clock, reset and preset and are compared against a rotation-count model.
module tb_p5_ring_counter;

  localparam logic [3:0] SEED4 = 4'b0001;
  localparam logic [5:0] SEED6 = 6'b000011;

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       preset = 1'b0;
  logic [3:0] q4;
  logic [5:0] q6;

  int checks = 0;
  int errors = 0;

  // Model: either cleared, or SEED rotated left by rotCount positions.
  bit modelZero = 1'b1;
  int rotCount  = 0;

  p5_ring_counter dutW4 (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .q      (q4)
  );

  p5_ring_counter #(.WIDTH(6), .SEED(SEED6)) dutW6 (
    .clk    (clk),
    .reset  (reset),
    .preset (preset),
    .q      (q6)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ringModel(int w, logic [31:0] seed, bit z, int k);
    longint unsigned mask;
    longint unsigned val;
    int m;
    if (z) return 32'd0;
    mask = (64'd1 << w) - 64'd1;
    val  = longint'(seed) & mask;
    m    = k % w;
    return 32'(((val << m) | (val >> (w - m))) & mask);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_w4"}, 32'(q4), ringModel(4, 32'(SEED4), modelZero, rotCount));
    checkOutput({tag, "_w6"}, 32'(q6), ringModel(6, 32'(SEED6), modelZero, rotCount));
    if (!modelZero) begin
      checkOutput({tag, "_pop4"}, 32'($countones(q4)), 32'($countones(SEED4)));
      checkOutput({tag, "_pop6"}, 32'($countones(q6)), 32'($countones(SEED6)));
    end
  endtask

  // Inputs only change between edges, so the model advances exactly on rising edges.
  task automatic clockTick(input string tag);
    @(posedge clk);
    if (reset && !preset && !modelZero) rotCount++;
    @(negedge clk);
    checkState(tag);
  endtask

  task automatic presetPulse();
    #1 preset = 1'b1;
    modelZero = 1'b0;
    rotCount  = 0;
    #1 checkState("presetImm");
    #1 preset = 1'b0;
  endtask

  task automatic resetPulse();
    #1 reset = 1'b0;
    modelZero = 1'b1;
    #1 checkState("resetImm");
    #1 reset = 1'b1;
  endtask

  task automatic applyStimulus(input int iterations);
    int r;
    int holdLen;
    for (int i = 0; i < iterations; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75) begin
        clockTick("randTick");
      end else if (r < 87) begin
        presetPulse();
        clockTick("randAfterPreset");
      end else if (r < 94) begin
        resetPulse();
        clockTick("randAfterReset");
      end else begin
        holdLen = int'($urandom_range(1, 3));
        #1 preset = 1'b1;
        modelZero = 1'b0;
        rotCount  = 0;
        for (int j = 0; j < holdLen; j++) clockTick("randHold");
        #1 preset = 1'b0;
        clockTick("randRelease");
      end
    end
  endtask

  logic [3:0] seq4 [5];
  logic [5:0] seq6 [7];

  initial begin
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq6 = '{6'b000011, 6'b000110, 6'b001100, 6'b011000, 6'b110000, 6'b100001, 6'b000011};

    // Reset held for about 100 ns with the clock running, preset briefly raised too.
    #1 reset = 1'b0;
    #1 checkState("resetAsserted");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) preset = 1'b1;
      if (i == 6) preset = 1'b0;
      #1 checkState("inReset");
    end
    reset = 1'b1;
    for (int i = 0; i < 10; i++) clockTick("afterReset");

    // Short preset pulse, then the literal rotation sequences.
    presetPulse();
    checkOutput("seq4_0", 32'(q4), 32'(seq4[0]));
    checkOutput("seq6_0", 32'(q6), 32'(seq6[0]));
    for (int i = 1; i < 7; i++) begin
      clockTick("seqTick");
      checkOutput("seq4", 32'(q4), 32'(seq4[i % 4]));
      checkOutput("seq6", 32'(q6), 32'(seq6[i]));
    end

    // Preset held across three rising edges, then released.
    #1 preset = 1'b1;
    modelZero = 1'b0;
    rotCount  = 0;
    for (int i = 0; i < 3; i++) clockTick("presetHold");
    #1 preset = 1'b0;
    clockTick("holdRelease");
    checkOutput("holdRelease4", 32'(q4), 32'h2);

    // Reset mid-sequence at 0100, preset during reset, then reset released under preset.
    clockTick("toFour");
    checkOutput("atFour", 32'(q4), 32'h4);
    #1 reset = 1'b0;
    modelZero = 1'b1;
    #1 checkState("midReset");
    preset = 1'b1;
    #1 checkState("resetAndPreset");
    reset = 1'b1;
    modelZero = 1'b0;
    rotCount  = 0;
    #1 checkState("releaseUnderPreset");
    preset = 1'b0;
    clockTick("afterReleaseUnderPreset");

    applyStimulus(300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p5_ring_counter.md
P5_RING_COUNTER -- requirements
Module: p5_ring_counter

Interface
REQ-001 Parameter WIDTH, default 4: number of ring stages and the width of q; legal range 2..32.
REQ-002 Parameter SEED, default 4'b0001 (WIDTH bits): pattern loaded by preset; any value is legal.
REQ-003 Port clk, input, 1 bit: single clock; all state changes occur on its rising edge, except reset and preset.
REQ-004 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-005 Port preset, input, 1 bit: asynchronous active-high load of SEED.
REQ-006 Port q, output, WIDTH bits: ring state, driven directly from flops with no combinational logic after the register.
REQ-007 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-008 State SHALL be one WIDTH-bit register whose value is q.
REQ-009 Rotation: on each rising clk edge, with reset high and preset low, q SHALL become {q[WIDTH-2:0], q[WIDTH-1]} (rotate toward MSB; MSB wraps to bit 0).
REQ-010 With the default SEED, the sequence SHALL be 0001 -> 0010 -> 0100 -> 1000 -> 0001, with period WIDTH clocks.
REQ-011 Rotation latency SHALL be one clock; q updates on the same rising edge with no pipeline stage.
REQ-012 Preset: while preset=1 and reset=1, q SHALL equal SEED immediately, without waiting for clk, and SHALL hold SEED while preset stays high.
REQ-013 A preset pulse shorter than one clock period SHALL still load SEED.
REQ-014 After preset deasserts, the first rising edge SHALL perform a normal rotation of SEED.
REQ-015 Rotation SHALL preserve the population count: an all-zero q stays 0000 until preset; any SEED pattern circulates unchanged in shape.
REQ-016 The block SHALL NOT self-correct a non-one-hot state; the pattern is defined solely by SEED.
REQ-017 Simultaneous events: reset low overrides preset and clk; preset high overrides clk.
REQ-018 q SHALL never be X or Z after the first assertion of reset or preset.

Reset
REQ-019 While reset=0, q SHALL be all zeros, asynchronously, regardless of clk or preset.
REQ-020 Reset asserted in the middle of a rotation sequence SHALL clear q immediately; the sequence position is lost.
REQ-021 After reset deasserts, q SHALL remain all zeros on every clk edge until preset is asserted.
REQ-022 Deasserting reset while preset=1 SHALL load SEED immediately.

Verification
REQ-023 Assert reset=0 for 100 ns with clk toggling every 5 ns, then release -> q=0000 throughout, and still 0000 over 10 further clocks.
REQ-024 After reset, pulse preset for 5 ns between clk edges -> q=0001 immediately; following edges give 0010, 0100, 1000, 0001.
REQ-025 Hold preset=1 across 3 rising edges -> q stays 0001; first edge after release gives 0010.
REQ-026 At q=0100, pull reset low between edges -> q=0000 before the next edge; with reset and preset both asserted, q stays 0000.
REQ-027 Instantiate with WIDTH=6, SEED=6'b000011 and preset -> 000011, 000110, 001100, 011000, 110000, 100001, 000011.
REQ-028 At every rising edge, check that q equals the rotate-left of the previous q, and that the popcount of q equals the popcount of SEED after preset.
